// File: rtl/systolic_feed_ctrl.sv
// Feed controller for the west edge of a systolic PE array: steers an interleaved
// operand stream into per-row FIFOs, then drains them with a one-cycle-per-row skew.
module systolic_feed_ctrl #(
    parameter int ROWS      = 32,
    parameter int ROWS_LOG2 = 5,
    parameter int FIFO_CAP  = 31,
    parameter int LEN_W     = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [LEN_W-1:0]     K_LEN,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [ROWS-1:0]      FIFO_FULL,
    input  logic [ROWS-1:0]      FIFO_EMPTY,
    output logic [ROWS-1:0]      PUSHE,
    output logic [ROWS-1:0]      POPE,
    output logic [ROWS_LOG2-1:0] ROW_SEL,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR
);

    localparam int T_W = LEN_W + 1;
    localparam logic [T_W-1:0]       CAP_T    = T_W'(FIFO_CAP);
    localparam logic [T_W-1:0]       TAIL_T   = T_W'(ROWS - 2);
    localparam logic [ROWS_LOG2-1:0] LAST_ROW = ROWS_LOG2'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [ROWS_LOG2-1:0] row_q, row_d;
    logic [LEN_W-1:0]     k_q, k_d;
    logic [T_W-1:0]       t_q, t_d;
    logic [LEN_W-1:0]     klen_q, klen_d;
    logic                 err_q, err_d;

    logic                 in_load;
    logic                 in_drain;
    logic                 accept;
    logic                 underflow;
    logic [ROWS-1:0]      pop_req;
    logic [T_W-1:0]       klen_t;
    logic [T_W-1:0]       last_t;

    assign in_load  = (state_q == S_LOAD);
    assign in_drain = (state_q == S_DRAIN);
    assign klen_t   = {1'b0, klen_q};
    assign last_t   = klen_t + TAIL_T;

    assign IN_READY = in_load & ~FIFO_FULL[row_q];
    assign accept   = IN_READY & IN_VALID;

    // Row gi pops on drain steps gi .. gi+klen-1; the t>=gi guard keeps t-gi from wrapping.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            localparam logic [T_W-1:0] ROW_T = T_W'(gi);
            assign PUSHE[gi]   = accept & (row_q == ROWS_LOG2'(gi));
            assign pop_req[gi] = in_drain & (t_q >= ROW_T) & ((t_q - ROW_T) < klen_t);
            assign POPE[gi]    = pop_req[gi] & ~FIFO_EMPTY[gi];
        end
    endgenerate

    assign underflow = |(pop_req & FIFO_EMPTY);

    assign ROW_SEL = in_load ? row_q : '0;
    assign BUSY    = in_load | in_drain;
    assign DONE    = (state_q == S_FIN);
    assign ERR     = err_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        k_d     = k_q;
        t_d     = t_q;
        klen_d  = klen_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    klen_d = K_LEN;
                    err_d  = 1'b0;
                    row_d  = '0;
                    k_d    = '0;
                    t_d    = '0;
                    if (K_LEN == '0) begin
                        state_d = S_FIN;
                    end else if ({1'b0, K_LEN} > CAP_T) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (row_q == LAST_ROW) begin
                        row_d = '0;
                        if (k_q == klen_q - LEN_W'(1)) begin
                            k_d     = '0;
                            state_d = S_DRAIN;
                        end else begin
                            k_d = k_q + LEN_W'(1);
                        end
                    end else begin
                        row_d = row_q + ROWS_LOG2'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (underflow) begin
                    err_d = 1'b1;
                end
                if (t_q == last_t) begin
                    t_d     = '0;
                    state_d = S_FIN;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            k_q     <= '0;
            t_q     <= '0;
            klen_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            k_q     <= k_d;
            t_q     <= t_d;
            klen_q  <= klen_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomised bench for systolic_feed_ctrl on a 4-row build, with behavioural FIFO
// occupancy and an expected push/pop schedule derived from the transfer rules.
module tb_systolic_feed_ctrl;

    localparam int ROWS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] k_len;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] fifo_full;
    logic [3:0] fifo_empty;
    logic [3:0] pushe;
    logic [3:0] pope;
    logic [1:0] row_sel;
    logic       busy;
    logic       done;
    logic       err;

    int         total = 0;
    int         bad = 0;
    int         cnt[ROWS];
    logic [3:0] pend_push;
    logic [3:0] pend_pop;
    logic [3:0] force_full;
    logic [3:0] force_empty;

    always #5 clk = ~clk;

    systolic_feed_ctrl #(
        .ROWS(4),
        .ROWS_LOG2(2),
        .FIFO_CAP(31),
        .LEN_W(6)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .START(start),
        .K_LEN(k_len),
        .IN_VALID(in_valid),
        .IN_READY(in_ready),
        .FIFO_FULL(fifo_full),
        .FIFO_EMPTY(fifo_empty),
        .PUSHE(pushe),
        .POPE(pope),
        .ROW_SEL(row_sel),
        .BUSY(busy),
        .DONE(done),
        .ERR(err)
    );

    // One clock: commit last cycle's pushes/pops to the FIFO model, drive inputs, sample outputs.
    task automatic step(input logic st, input logic [5:0] kl, input logic vld);
        @(posedge clk);
        for (int r = 0; r < ROWS; r++)
            cnt[r] = cnt[r] + int'(pend_push[r]) - int'(pend_pop[r]);
        #1;
        start    = st;
        k_len    = kl;
        in_valid = vld;
        for (int r = 0; r < ROWS; r++) begin
            fifo_full[r]  = (cnt[r] >= 31) || force_full[r];
            fifo_empty[r] = (cnt[r] == 0) || force_empty[r];
        end
        #1;
        pend_push = pushe;
        pend_pop  = pope;
    endtask

    task automatic run_transfer(input int kl, input int vprob, input int stall_row,
                                input int stall_len, input logic [3:0] fempty,
                                input bit inject, input string tag);
        int         pushes;
        int         stalls;
        int         cyc;
        bit         vld;
        bit         stall_now;
        bit         st;
        bit         u;
        logic [3:0] exp_push;
        logic [3:0] exp_pope;
        logic [1:0] exp_sel;
        logic       err_acc;
        int         exp_cnt;

        for (int r = 0; r < ROWS; r++) cnt[r] = 0;
        pend_push   = '0;
        pend_pop    = '0;
        force_full  = '0;
        force_empty = fempty;

        step(1'b1, 6'(kl), 1'b0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_before_accept got=%b exp=0", tag, busy);
        end

        pushes = 0;
        stalls = 0;
        cyc    = 0;
        while (pushes < kl * ROWS && cyc < 3000) begin
            stall_now  = ((pushes % ROWS) == stall_row) && (stalls < stall_len);
            force_full = stall_now ? 4'(1 << stall_row) : 4'b0;
            vld        = ($urandom_range(0, 99) < vprob);
            st         = inject && ($urandom_range(0, 5) == 0);
            step(st, 6'($urandom_range(0, 63)), vld);
            exp_push = (vld && !stall_now) ? 4'(1 << (pushes % ROWS)) : 4'b0;
            exp_sel  = 2'(pushes % ROWS);
            total++;
            if (pushe !== exp_push) begin
                bad++;
                $display("FAIL %s pushe push#%0d got=%b exp=%b", tag, pushes, pushe, exp_push);
            end
            total++;
            if (in_ready !== !stall_now) begin
                bad++;
                $display("FAIL %s in_ready push#%0d got=%b exp=%b", tag, pushes, in_ready, !stall_now);
            end
            total++;
            if (row_sel !== exp_sel) begin
                bad++;
                $display("FAIL %s row_sel push#%0d got=%0d exp=%0d", tag, pushes, row_sel, exp_sel);
            end
            total++;
            if (busy !== 1'b1 || done !== 1'b0 || pope !== 4'b0 || err !== 1'b0) begin
                bad++;
                $display("FAIL %s load_status busy=%b done=%b pope=%b err=%b exp busy=1 done=0 pope=0000 err=0",
                         tag, busy, done, pope, err);
            end
            if (stall_now) stalls++;
            if (exp_push != 4'b0) pushes++;
            cyc++;
        end
        total++;
        if (cyc >= 3000) begin
            bad++;
            $display("FAIL %s load_timeout pushes=%0d exp=%0d", tag, pushes, kl * ROWS);
        end
        force_full = '0;

        err_acc = 1'b0;
        for (int t = 0; t < kl + ROWS - 1; t++) begin
            st = inject && ($urandom_range(0, 5) == 0);
            step(st, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            exp_pope = '0;
            u        = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                if (t >= r && t - r < kl) begin
                    if (fempty[r]) u = 1'b1;
                    else exp_pope[r] = 1'b1;
                end
            end
            total++;
            if (pope !== exp_pope) begin
                bad++;
                $display("FAIL %s pope t=%0d got=%b exp=%b", tag, t, pope, exp_pope);
            end
            total++;
            if (err !== err_acc) begin
                bad++;
                $display("FAIL %s drain_err t=%0d got=%b exp=%b", tag, t, err, err_acc);
            end
            total++;
            if (pushe !== 4'b0 || in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s drain_status t=%0d pushe=%b ready=%b busy=%b done=%b exp 0000/0/1/0",
                         tag, t, pushe, in_ready, busy, done);
            end
            if (u) err_acc = 1'b1;
        end

        step(1'b0, 6'd0, 1'b0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== err_acc || pope !== 4'b0) begin
            bad++;
            $display("FAIL %s fin done=%b busy=%b err=%b pope=%b exp done=1 busy=0 err=%b pope=0000",
                     tag, done, busy, err, pope, err_acc);
        end
        step(1'b0, 6'd0, 1'b0);
        total++;
        if (done !== 1'b0 || err !== err_acc) begin
            bad++;
            $display("FAIL %s after_fin done=%b err=%b exp done=0 err=%b", tag, done, err, err_acc);
        end
        for (int r = 0; r < ROWS; r++) begin
            exp_cnt = fempty[r] ? kl : 0;
            total++;
            if (cnt[r] !== exp_cnt) begin
                bad++;
                $display("FAIL %s fifo_level row=%0d got=%0d exp=%0d", tag, r, cnt[r], exp_cnt);
            end
        end
        force_empty = '0;
        $display("transfer %s klen=%0d stalls=%0d fempty=%b err=%b", tag, kl, stalls, fempty, err_acc);
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        start       = 1'b0;
        k_len       = '0;
        in_valid    = 1'b0;
        fifo_full   = '0;
        fifo_empty  = '1;
        pend_push   = '0;
        pend_pop    = '0;
        force_full  = '0;
        force_empty = '0;
        for (int r = 0; r < ROWS; r++) cnt[r] = 0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (in_ready !== 1'b0 || pushe !== 4'b0 || pope !== 4'b0 || busy !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || row_sel !== 2'd0) begin
            bad++;
            $display("FAIL reset_state ready=%b pushe=%b pope=%b busy=%b done=%b err=%b sel=%0d exp all 0",
                     in_ready, pushe, pope, busy, done, err, row_sel);
        end
        rst = 1'b0;
        $display("reset state checked");

        step(1'b1, 6'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 6'd0, 1'b1);
            total++;
            if (pushe !== 4'(1 << i)) begin
                bad++;
                $display("FAIL reset_preload pushe word=%0d got=%b exp=%b", i, pushe, 4'(1 << i));
            end
        end
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || pushe !== 4'b0 || in_ready !== 1'b0 || done !== 1'b0 || row_sel !== 2'd0) begin
            bad++;
            $display("FAIL reset_midload busy=%b pushe=%b ready=%b done=%b sel=%0d exp 0",
                     busy, pushe, in_ready, done, row_sel);
        end
        step(1'b0, 6'd0, 1'b1);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold busy=%b done=%b exp 0/0", busy, done);
        end
        rst = 1'b0;
        $display("reset mid-load checked");
        run_transfer(1, 100, -1, 0, 4'b0000, 1'b0, "post_reset");
    endtask

    task automatic test_nominal();
        run_transfer(3, 100, -1, 0, 4'b0000, 1'b0, "nominal");
    endtask

    task automatic test_backpressure();
        run_transfer(3, 100, 2, 5, 4'b0000, 1'b0, "backpressure");
    endtask

    task automatic test_underflow();
        run_transfer(3, 100, -1, 0, 4'b0010, 1'b0, "underflow");
    endtask

    task automatic test_len_over();
        logic [5:0] kl;
        for (int i = 0; i < 3; i++) begin
            kl = (i == 0) ? 6'd32 : 6'($urandom_range(32, 63));
            step(1'b1, kl, 1'b1);
            step(1'b0, 6'd0, 1'b1);
            total++;
            if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || pushe !== 4'b0 || pope !== 4'b0) begin
                bad++;
                $display("FAIL len_over klen=%0d done=%b err=%b busy=%b pushe=%b pope=%b exp 1/1/0/0000/0000",
                         kl, done, err, busy, pushe, pope);
            end
            step(1'b0, 6'd0, 1'b1);
            total++;
            if (done !== 1'b0 || err !== 1'b1) begin
                bad++;
                $display("FAIL len_over_sticky klen=%0d done=%b err=%b exp 0/1", kl, done, err);
            end
            $display("len_over klen=%0d err=%b", kl, err);
        end
    endtask

    task automatic test_len_zero();
        step(1'b1, 6'd0, 1'b1);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL len_zero_early done=%b exp 0", done);
        end
        step(1'b0, 6'd0, 1'b1);
        total++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || pushe !== 4'b0 ||
            pope !== 4'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL len_zero done=%b err=%b busy=%b pushe=%b pope=%b ready=%b exp 1/0/0/0000/0000/0",
                     done, err, busy, pushe, pope, in_ready);
        end
        step(1'b0, 6'd0, 1'b1);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL len_zero_pulse done=%b exp 0", done);
        end
        $display("len_zero checked");
    endtask

    task automatic test_len_max();
        run_transfer(31, 90, -1, 0, 4'b0000, 1'b0, "len_max");
    endtask

    task automatic test_ignored_start();
        run_transfer(3, 80, -1, 0, 4'b0000, 1'b1, "ignored_start");
    endtask

    task automatic test_random();
        int         kl;
        int         srow;
        logic [3:0] fe;
        for (int i = 0; i < 8; i++) begin
            kl   = $urandom_range(1, 31);
            srow = $urandom_range(0, ROWS - 1);
            fe   = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, ROWS - 1)) : 4'b0;
            run_transfer(kl, 70, srow, $urandom_range(0, 5), fe, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_underflow();
        test_len_over();
        test_len_zero();
        test_len_max();
        test_ignored_start();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
